// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: capture FSM states, plot-window geometry, sample width.
package osc_pkg;

  localparam int unsigned SAMPLE_W = 8;

  // Plot window: X0 <= x < X0+DEPTH, Y0 <= y < Y1
  localparam int unsigned X0 = 100;
  localparam int unsigned Y0 = 200;
  localparam int unsigned Y1 = 456;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StWaitTrig,
    StPost,
    StDone
  } cap_state_e;

  // Modular add for operands already reduced below m; never relies on binary wrap.
  function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned m);
    return ((a + b) >= m) ? (a + b - m) : (a + b);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM, two banks of DEPTH samples with the bank bit as MSB; registered read.
module capture_ram
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH = 200,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic                wr_bank,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_bank,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Triggered, double-buffered ADC record capture with pixel-column replay for the VGA plot window.
// Build option: define AUTO_TRIG_EN to force a trigger after 2^20 clocks in WAIT_TRIG.
module trigger_capture
  import osc_pkg::*;
#(
  parameter int unsigned DEPTH   = 200,
  parameter int unsigned PRE     = 50,
  parameter int unsigned HOLDOFF = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic                single_mode,
  input  logic                arm,
  input  logic                frame_start,
  input  logic [9:0]          value_x,
  input  logic [9:0]          value_y,
  output logic [SAMPLE_W-1:0] wave_data,
  output logic                trig_seen,
  output logic                capture_done,
  output logic                busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + HOLDOFF + 1);

  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(PRE + HOLDOFF - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE - 1);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + DEPTH);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y1);

  cap_state_e          state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, next_ptr;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       trig_addr_q, trig_addr_d;
  logic [AW-1:0]       disp_start_q, disp_start_d;
  logic                wr_bank_q, wr_bank_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic                trig_seen_q, trig_seen_d;
  logic                done_q, done_d;
  logic                in_win_q, in_win;
  logic                wr_en, trig_hit, start_fill, timeout;
  logic [AW-1:0]       rd_addr;
  logic [SAMPLE_W-1:0] rd_data;

`ifdef AUTO_TRIG_EN
  logic [19:0] to_cnt_q, to_cnt_d;

  assign to_cnt_d = (state_q == StWaitTrig) ? to_cnt_q + 20'd1 : 20'd0;
  assign timeout  = (state_q == StWaitTrig) && (to_cnt_q == 20'hf_ffff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy     = state_q inside {StFill, StWaitTrig, StPost};
  assign next_ptr = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
  assign trig_hit = prev_vld_q &&
                    (trig_falling ? (prev_q >= trig_level) && (trig_level > adc_data)
                                  : (prev_q < trig_level) && (trig_level <= adc_data));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    trig_addr_d  = trig_addr_q;
    disp_start_d = disp_start_q;
    wr_bank_d    = wr_bank_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    trig_seen_d  = trig_seen_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    start_fill   = 1'b0;

    if (adc_valid) begin
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!single_mode || arm) start_fill = 1'b1;
      end
      StFill: begin
        if (adc_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = next_ptr;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == FILL_LAST) begin
            state_d = StWaitTrig;
            cnt_d   = '0;
          end
        end
      end
      StWaitTrig: begin
        if (adc_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = next_ptr;
        end
        if (adc_valid && trig_hit) begin
          state_d     = StPost;
          trig_addr_d = wr_ptr_q;
          trig_seen_d = 1'b1;
          cnt_d       = CW'(1);
        end else if (timeout) begin
          // Forced record: a sample written this cycle is the trigger sample
          state_d     = StPost;
          trig_addr_d = wr_ptr_q;
          cnt_d       = adc_valid ? CW'(1) : '0;
        end
      end
      StPost: begin
        if (adc_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = next_ptr;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == POST_LAST) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        if (frame_start) begin
          wr_bank_d    = ~wr_bank_q;
          disp_start_d = AW'(mod_add(32'(trig_addr_q), DEPTH - PRE, DEPTH));
          if (single_mode) begin
            state_d = StIdle;
          end else begin
            start_fill = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (single_mode && arm && busy) start_fill = 1'b1;

    // A strobe coinciding with (re)arm is dropped so the record starts clean at address 0
    if (start_fill) begin
      state_d     = StFill;
      wr_en       = 1'b0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      prev_vld_d  = 1'b0;
      trig_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      trig_addr_q  <= '0;
      disp_start_q <= '0;
      wr_bank_q    <= 1'b0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      trig_seen_q  <= 1'b0;
      done_q       <= 1'b0;
      in_win_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      trig_addr_q  <= trig_addr_d;
      disp_start_q <= disp_start_d;
      wr_bank_q    <= wr_bank_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      trig_seen_q  <= trig_seen_d;
      done_q       <= done_d;
      in_win_q     <= in_win;
    end
  end

  assign in_win  = (value_x >= X_LO) && (value_x < X_HI) && (value_y >= Y_LO) && (value_y < Y_HI);
  assign rd_addr = AW'(mod_add(32'(disp_start_q), 32'(value_x - X_LO), DEPTH));

  capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (adc_data),
    .rd_bank (~wr_bank_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wave_data    = in_win_q ? rd_data : '0;
  assign trig_seen    = trig_seen_q;
  assign capture_done = done_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: directed captures, readout, bank swap and reset cases.
module tb_trigger_capture;
  import osc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] adc_data = '0;
  logic       adc_valid = 1'b0;
  logic [7:0] trig_level = 8'd128;
  logic       trig_falling = 1'b0;
  logic       single_mode = 1'b1;
  logic       arm = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] value_x = '0;
  logic [9:0] value_y = '0;
  logic [7:0] wave_data;
  logic       trig_seen;
  logic       capture_done;
  logic       busy;

  always #5 clk = ~clk;

  trigger_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .single_mode  (single_mode),
    .arm          (arm),
    .frame_start  (frame_start),
    .value_x      (value_x),
    .value_y      (value_y),
    .wave_data    (wave_data),
    .trig_seen    (trig_seen),
    .capture_done (capture_done),
    .busy         (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t done_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic probe = 1'b0;
  logic probe_q = 1'b0;

  always @(posedge clk) probe_q <= probe;

  // Monitor: one wave_data compare per probed column, one trig_seen compare per capture_done
  always @(negedge clk) begin
    exp_t e;
    if (probe_q) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_underflow: wave_data=%0d with no expectation queued", wave_data);
      end else begin
        e = rd_q.pop_front();
        if (wave_data !== e.exp) begin
          n_err++;
          $display("FAIL %s: wave_data got %0d expected %0d", e.name, wave_data, e.exp);
        end
      end
    end
    if (capture_done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_capture_done: got pulse expected none at %0t", $time);
      end else begin
        e = done_q.pop_front();
        if (8'(trig_seen) !== e.exp) begin
          n_err++;
          $display("FAIL %s: trig_seen at done got %0d expected %0d", e.name, trig_seen, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic seen);
    exp_t e;
    e.name = name;
    e.exp  = 8'(seen);
    done_q.push_back(e);
  endtask

  task automatic rd(input int x, input int y, input logic [7:0] exp, input string name);
    exp_t e;
    e.name  = name;
    e.exp   = exp;
    rd_q.push_back(e);
    value_x = 10'(x);
    value_y = 10'(y);
    probe   = 1'b1;
    tick();
    probe   = 1'b0;
  endtask

  // Ramp k mod 256 from a fresh arm, rising through 128: trigger at addr 128, start 78
  task automatic ramp_capture(input string name);
    for (int k = 0; k < 278; k++) begin
      if (k == 277) expect_done(name, 1'b1);
      put(8'(k));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_wave_data", wave_data, 8'd0);
    chk("reset_trig_seen", 8'(trig_seen), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_capture_done", 8'(capture_done), 8'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("single_idle_not_busy", 8'(busy), 8'd0);

    // Ramp, rising at 128
    pulse_arm();
    chk("arm_busy", 8'(busy), 8'd1);
    ramp_capture("t1_done");
    chk("t1_trig_seen", 8'(trig_seen), 8'd1);
    chk("t1_done_not_busy", 8'(busy), 8'd0);
    repeat (2) tick();
    pulse_frame();
    rd(X0, Y0, 8'd78, "t1_col_x0");
    rd(X0 + 50, Y0 + 10, 8'd128, "t1_col_trig");
    rd(X0 + 199, Y1 - 1, 8'd21, "t1_col_last");
    rd(X0 - 1, Y0, 8'd0, "t1_left_of_win");
    rd(X0 + 200, Y0, 8'd0, "t1_right_of_win");
    rd(X0 + 50, Y0 - 1, 8'd0, "t1_above_win");
    rd(X0 + 50, Y1, 8'd0, "t1_below_win");

    // Falling trigger landing at write addr 10; stray frame_start in FILL and on final strobe
    trig_level   = 8'd100;
    trig_falling = 1'b1;
    pulse_arm();
    chk("rearm_clears_seen", 8'(trig_seen), 8'd0);
    for (int k = 0; k < 360; k++) begin
      frame_start = (k == 20) || (k == 359);
      if (k == 359) expect_done("t3_done", 1'b1);
      put((k < 210) ? 8'(100 + k % 100) : 8'(k % 100));
      frame_start = 1'b0;
    end
    rd(X0 + 50, Y0, 8'd128, "t4_hold_old_trig");
    rd(X0, Y0, 8'd78, "t4_hold_old_x0");
    pulse_frame();
    rd(X0 + 40, Y0, 8'd100, "t3_wrap_addr0");
    rd(X0, Y0, 8'd160, "t3_col_x0");
    rd(X0 + 49, Y0, 8'd109, "t3_col_pre_last");
    rd(X0 + 50, Y0, 8'd10, "t3_col_trig");
    rd(X0 + 199, Y0, 8'd59, "t3_col_last");

    // Single mode: further crossings ignored without arm
    for (int i = 0; i < 20; i++) begin
      put(8'd200);
      put(8'd10);
    end
    chk("t2_stays_idle", 8'(busy), 8'd0);
    chk("t2_seen_held", 8'(trig_seen), 8'd1);
    pulse_frame();
    rd(X0 + 50, Y0, 8'd10, "t2_no_new_record");

    // DC below level never triggers
    trig_level   = 8'd128;
    trig_falling = 1'b0;
    pulse_arm();
    repeat (3000) put(8'd20);
    chk("t5_still_waiting", 8'(busy), 8'd1);
    chk("t5_no_trig_seen", 8'(trig_seen), 8'd0);

    // Arm while busy restarts a clean capture
    pulse_arm();
    chk("rearm_busy", 8'(busy), 8'd1);
    ramp_capture("rearm_done");
    pulse_frame();
    rd(X0, Y0, 8'd78, "rearm_col_x0");
    rd(X0 + 50, Y0, 8'd128, "rearm_col_trig");

    // Reset during POST
    value_x = 10'(X0 + 50);
    value_y = 10'(Y0 + 5);
    pulse_arm();
    for (int k = 0; k <= 150; k++) put(8'(k));
    chk("t6_post_seen", 8'(trig_seen), 8'd1);
    chk("t6_post_busy", 8'(busy), 8'd1);
    chk("t6_pre_reset_wave", wave_data, 8'd128);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wave", wave_data, 8'd0);
    chk("t6_rst_busy", 8'(busy), 8'd0);
    chk("t6_rst_seen", 8'(trig_seen), 8'd0);
    chk("t6_rst_done", 8'(capture_done), 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_arm();
    ramp_capture("t6_done");
    pulse_frame();
    rd(X0, Y0, 8'd78, "t6_col_x0");
    rd(X0 + 50, Y0, 8'd128, "t6_col_trig");
    rd(X0 + 199, Y0, 8'd21, "t6_col_last");
    repeat (2) tick();

    chk("captures_outstanding", 8'(done_q.size()), 8'd0);
    chk("reads_outstanding", 8'(rd_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run incomplete");
    $fatal(1);
  end

endmodule
